// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM states, bit-slot quarter phases and ACK encoding.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        TX_BYTE,
        RX_ACK,
        STOP
    } i2c_mst_state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } i2c_qphase_t;

    localparam int   NUM_BYTES = 3;
    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;

endpackage

// File: rtl/i2c_write_master_if.sv
// Request handshake plus open-drain SCL/SDA pad triplets of the I2C write master.
interface i2c_write_master_if;

    logic       start;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl_i;
    logic       scl_o;
    logic       scl_t;
    logic       sda_i;
    logic       sda_o;
    logic       sda_t;

    modport master (
        input  start, dev_addr, reg_addr, wr_data, scl_i, sda_i,
        output busy, done, ack_err, scl_o, scl_t, sda_o, sda_t
    );

    modport slave (
        output start, dev_addr, reg_addr, wr_data, scl_i, sda_i,
        input  busy, done, ack_err, scl_o, scl_t, sda_o, sda_t
    );

endinterface

// File: rtl/i2c_qtick.sv
// Quarter-period tick generator: qtick fires every CLK_DIV cycles.
// Latency: qtick combinational from the counter; clr parks the counter at 0.
// Backpressure: hold freezes the counter (SCL stretching) without losing phase.
module i2c_qtick #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hold,
    output logic qtick
);

    localparam int            CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign qtick = !clr && !hold && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= qtick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// Single-master I2C writer: START, {dev,W}, reg, data with ACK checks, then STOP.
// Latency: 116*CLK_DIV+1 cycles start-to-done without stretching or NACK.
// Backpressure: start ignored while busy or during done; SCL stretch freezes timing.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_write_master_if.master bus
);

    localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);

    i2c_mst_state_t state,    state_n;
    i2c_qphase_t    phase,    phase_n;
    logic [2:0]     bit_cnt,  bit_cnt_n;
    logic [1:0]     byte_idx, byte_idx_n;
    logic [7:0]     sreg,     sreg_n;
    logic [7:0]     reg_q,    reg_q_n;
    logic [7:0]     data_q,   data_q_n;
    logic           ack_smp,  ack_smp_n;
    logic           ack_err_q, ack_err_n;
    logic           done_q,   done_n;
    logic           qtick;
    logic           q_clr;
    logic           q_hold;
    logic           scl_rel;
    logic           sda_rel;

    // Stretch only matters once we have released SCL after driving it low.
    assign q_clr  = (state == IDLE);
    assign q_hold = (phase == Q2) && !bus.scl_i &&
                    ((state == TX_BYTE) || (state == RX_ACK) || (state == STOP));

    i2c_qtick #(
        .CLK_DIV (CLK_DIV)
    ) u_qtick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (q_clr),
        .hold  (q_hold),
        .qtick (qtick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= Q0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            sreg      <= '0;
            reg_q     <= '0;
            data_q    <= '0;
            ack_smp   <= NACK;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            bit_cnt   <= bit_cnt_n;
            byte_idx  <= byte_idx_n;
            sreg      <= sreg_n;
            reg_q     <= reg_q_n;
            data_q    <= data_q_n;
            ack_smp   <= ack_smp_n;
            ack_err_q <= ack_err_n;
            done_q    <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        bit_cnt_n  = bit_cnt;
        byte_idx_n = byte_idx;
        sreg_n     = sreg;
        reg_q_n    = reg_q;
        data_q_n   = data_q;
        ack_smp_n  = ack_smp;
        ack_err_n  = ack_err_q;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                // done_q high means we are in the completion cycle; that start is dropped.
                if (bus.start && !done_q) begin
                    reg_q_n    = bus.reg_addr;
                    data_q_n   = bus.wr_data;
                    sreg_n     = {bus.dev_addr, 1'b0};
                    byte_idx_n = '0;
                    bit_cnt_n  = '0;
                    ack_err_n  = 1'b0;
                    phase_n    = Q0;
                    state_n    = START;
                end
            end
            default: begin
                if (qtick) begin
                    phase_n = i2c_qphase_t'(phase + 2'd1);
                    if ((state == RX_ACK) && (phase == Q2)) begin
                        ack_smp_n = bus.sda_i;
                    end
                    if (phase == Q3) begin
                        case (state)
                            START: begin
                                bit_cnt_n = '0;
                                state_n   = TX_BYTE;
                            end
                            TX_BYTE: begin
                                sreg_n = {sreg[6:0], 1'b0};
                                if (bit_cnt == 3'd7) begin
                                    state_n = RX_ACK;
                                end else begin
                                    bit_cnt_n = bit_cnt + 3'd1;
                                end
                            end
                            RX_ACK: begin
                                if (ack_smp != ACK) begin
                                    ack_err_n = 1'b1;
                                    state_n   = STOP;
                                end else if (byte_idx == LAST_BYTE) begin
                                    state_n = STOP;
                                end else begin
                                    byte_idx_n = byte_idx + 2'd1;
                                    sreg_n     = (byte_idx == 2'd0) ? reg_q : data_q;
                                    bit_cnt_n  = '0;
                                    state_n    = TX_BYTE;
                                end
                            end
                            STOP: begin
                                done_n  = 1'b1;
                                state_n = IDLE;
                            end
                            default: state_n = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Pad enables decode straight from state so a reset releases the bus immediately.
    always_comb begin
        scl_rel = 1'b1;
        sda_rel = 1'b1;
        case (state)
            START: begin
                scl_rel = (phase != Q3);
                sda_rel = (phase == Q0) || (phase == Q1);
            end
            TX_BYTE: begin
                scl_rel = (phase != Q0);
                sda_rel = sreg[7];
            end
            RX_ACK: begin
                scl_rel = (phase != Q0);
            end
            STOP: begin
                scl_rel = (phase != Q0);
                sda_rel = (phase == Q3);
            end
            default: begin
                scl_rel = 1'b1;
                sda_rel = 1'b1;
            end
        endcase
    end

    assign bus.scl_o   = 1'b0;
    assign bus.sda_o   = 1'b0;
    assign bus.scl_t   = scl_rel;
    assign bus.sda_t   = sda_rel;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_write_master.sv
`timescale 1ns/1ps
module tb_i2c_write_master;
    import i2c_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int NO_NACK = 3;

    typedef struct {
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] dat;
        int         nack_at;
        bit         strch;
        bit         extra;
        int         exp_lat;
        int         exp_err;
        int         exp_pulses;
    } vec_t;

    typedef struct {
        int              lat;
        int              err;
        int              pulses;
        int              nstart;
        int              nstop;
        logic [2:0][7:0] bytes;
        int              stretch_moves;
        int              stretched;
        int              busy1;
        int              err0;
        int              err1;
        int              busy_after;
        int              done_after;
        int              extra_done;
        int              err_hold;
        int              aborted;
        int              pre_scl;
        int              rst_scl;
        int              rst_sda;
        int              rst_busy;
        int              rst_err;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stretch = 1'b0;
    logic pull = 1'b0;
    int   checks = 0;
    int   errors = 0;

    i2c_write_master_if bus ();

    assign bus.scl_i = bus.scl_t & ~stretch;
    assign bus.sda_i = bus.sda_t & ~pull;

    i2c_write_master #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: bytes sent, SCL pulses and completion time from the framing rules.
    function automatic int model_bytes(input int nack_at);
        return (nack_at < NUM_BYTES) ? nack_at + 1 : NUM_BYTES;
    endfunction

    function automatic int model_latency(input int nack_at, input int stretch_cyc);
        return (1 + 9 * model_bytes(nack_at) + 1) * 4 * CLK_DIV + 1 + stretch_cyc;
    endfunction

    task automatic run_txn(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] dat,
                           input int nack_at, input bit do_stretch, input bit extra,
                           input int rst_at, output obs_t o);
        int         pulses;
        int         left;
        bit         prev_scl, prev_sda, scl_l, sda_l, had_rise, rbit, str_done;
        logic       prev_sdat;
        logic [7:0] cur;
        o.lat = -1; o.err = 0; o.pulses = 0; o.nstart = 0; o.nstop = 0; o.bytes = '0;
        o.stretch_moves = 0; o.stretched = 0; o.busy1 = 0; o.err0 = 0; o.err1 = 0;
        o.busy_after = 0; o.done_after = 0; o.extra_done = 0; o.err_hold = 0; o.aborted = 0;
        o.pre_scl = 0; o.rst_scl = 0; o.rst_sda = 0; o.rst_busy = 0; o.rst_err = 0;
        @(negedge clk);
        o.err0 = int'(bus.ack_err);
        bus.dev_addr = dev; bus.reg_addr = rg; bus.wr_data = dat; bus.start = 1'b1;
        prev_scl = 1'b1; prev_sda = 1'b1; had_rise = 1'b0; rbit = 1'b0; str_done = 1'b0;
        pulses = 0; left = 0; cur = '0; prev_sdat = bus.sda_t;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (extra && (cyc == 10 || cyc == 200)) begin
                bus.start = 1'b1; bus.dev_addr = ~dev; bus.reg_addr = ~rg; bus.wr_data = ~dat;
            end
            if (cyc == 1) begin
                o.busy1 = int'(bus.busy);
                o.err1  = int'(bus.ack_err);
            end
            if (stretch) begin
                if (bus.sda_t != prev_sdat) o.stretch_moves++;
                left--;
                if (left == 0) stretch = 1'b0;
            end else if (do_stretch && !str_done && pulses == 12 && bus.scl_t) begin
                // Hold SCL through q1 plus 20 cycles of q2.
                stretch = 1'b1; left = CLK_DIV + 20; str_done = 1'b1; o.stretched = 1;
            end
            prev_sdat = bus.sda_t;
            scl_l = bus.scl_t & ~stretch;
            sda_l = bus.sda_t & ~pull;
            if (prev_scl && scl_l && sda_l != prev_sda) begin
                if (!sda_l) o.nstart++;
                else        o.nstop++;
            end
            if (!prev_scl && scl_l) begin
                had_rise = 1'b1;
                rbit = sda_l;
            end
            if (prev_scl && !scl_l && had_rise) begin
                had_rise = 1'b0;
                if (pulses % 9 < 8) cur = {cur[6:0], rbit};
                if (pulses % 9 == 7 && pulses / 9 < 3) o.bytes[2'(pulses / 9)] = cur;
                pulses++;
                pull = (pulses % 9 == 8) && (pulses / 9 != nack_at);
                sda_l = bus.sda_t & ~pull;
            end
            prev_scl = scl_l;
            prev_sda = sda_l;
            if (rst_at >= 0 && pulses == rst_at) begin
                o.pre_scl = int'(bus.scl_t);
                #1 rst_n = 1'b0;
                #1;
                o.rst_scl = int'(bus.scl_t); o.rst_sda = int'(bus.sda_t);
                o.rst_busy = int'(bus.busy); o.rst_err = int'(bus.ack_err);
                o.aborted = 1;
                stretch = 1'b0; pull = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            if (bus.done) begin
                o.lat = cyc;
                break;
            end
        end
        o.pulses = pulses;
        bus.start = 1'b0;
        stretch = 1'b0;
        pull = 1'b0;
        if (o.aborted == 0 && o.lat > 0) begin
            o.err = int'(bus.ack_err);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            o.busy_after = int'(bus.busy);
            o.done_after = int'(bus.done);
            repeat (4) begin
                @(negedge clk);
                if (bus.done) o.extra_done++;
            end
            o.err_hold = int'(bus.ack_err);
        end
    endtask

    task automatic check_txn(input string tag, input vec_t v, input obs_t o, input int prev_err);
        logic [7:0] eb [3];
        eb[0] = {v.dev, 1'b0};
        eb[1] = v.rg;
        eb[2] = v.dat;
        check({tag, " done latency"}, o.lat, v.exp_lat);
        check({tag, " ack_err at done"}, o.err, v.exp_err);
        check({tag, " scl pulses"}, o.pulses, v.exp_pulses);
        check({tag, " start conds"}, o.nstart, 1);
        check({tag, " stop conds"}, o.nstop, 1);
        check({tag, " busy after start"}, o.busy1, 1);
        check({tag, " ack_err before start"}, o.err0, prev_err);
        check({tag, " ack_err cleared"}, o.err1, 0);
        check({tag, " start in done cycle busy"}, o.busy_after, 0);
        check({tag, " single done pulse"}, o.done_after + o.extra_done, 0);
        check({tag, " ack_err held"}, o.err_hold, v.exp_err);
        check({tag, " sda moves while stretched"}, o.stretch_moves, 0);
        check({tag, " stretch applied"}, o.stretched, int'(v.strch && v.exp_pulses > 12));
        for (int i = 0; i < 3; i++) begin
            if (i < v.exp_pulses / 9) begin
                check($sformatf("%s byte%0d", tag, i), int'(o.bytes[i]), int'(eb[i]));
            end
        end
    endtask

    initial begin
        vec_t vecs [6];
        vec_t v;
        obs_t o;
        int   prev_err;

        vecs[0] = '{7'h50, 8'h10, 8'hA5, NO_NACK, 1'b0, 1'b0, 465, 0, 27};
        vecs[1] = '{7'h50, 8'h10, 8'hA5, 0,       1'b0, 1'b0, 177, 1, 9};
        vecs[2] = '{7'h50, 8'h10, 8'hA5, 2,       1'b0, 1'b0, 465, 1, 27};
        vecs[3] = '{7'h50, 8'h10, 8'hA5, 1,       1'b0, 1'b0, 321, 1, 18};
        vecs[4] = '{7'h50, 8'h10, 8'hA5, NO_NACK, 1'b1, 1'b0, 485, 0, 27};
        vecs[5] = '{7'h3C, 8'hC3, 8'h5A, NO_NACK, 1'b0, 1'b1, 465, 0, 27};

        bus.start = 1'b0; bus.dev_addr = '0; bus.reg_addr = '0; bus.wr_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset scl_t", int'(bus.scl_t), 1);
        check("reset sda_t", int'(bus.sda_t), 1);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset ack_err", int'(bus.ack_err), 0);
        check("scl_o", int'(bus.scl_o), 0);
        check("sda_o", int'(bus.sda_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        prev_err = 0;
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].dev, vecs[i].rg, vecs[i].dat, vecs[i].nack_at,
                    vecs[i].strch, vecs[i].extra, -1, o);
            check_txn($sformatf("vec%0d", i), vecs[i], o, prev_err);
            prev_err = vecs[i].exp_err;
        end

        // Reset while the register byte is on the wire.
        run_txn(7'h50, 8'h10, 8'hA5, NO_NACK, 1'b0, 1'b0, 13, o);
        check("rst reached", o.aborted, 1);
        check("rst scl low before", o.pre_scl, 0);
        check("rst scl_t released", o.rst_scl, 1);
        check("rst sda_t released", o.rst_sda, 1);
        check("rst busy", o.rst_busy, 0);
        check("rst ack_err", o.rst_err, 0);
        check("rst no stop", o.nstop, 0);
        prev_err = 0;
        run_txn(vecs[0].dev, vecs[0].rg, vecs[0].dat, NO_NACK, 1'b0, 1'b0, -1, o);
        check_txn("post-reset", vecs[0], o, prev_err);
        prev_err = 0;

        for (int n = 0; n < 12; n++) begin
            v.dev        = 7'($urandom);
            v.rg         = 8'($urandom);
            v.dat        = 8'($urandom);
            v.nack_at    = int'($urandom_range(0, 3));
            v.strch      = 1'($urandom_range(0, 1));
            v.extra      = 1'($urandom_range(0, 1));
            v.exp_pulses = 9 * model_bytes(v.nack_at);
            v.exp_err    = (v.nack_at < NUM_BYTES) ? 1 : 0;
            v.exp_lat    = model_latency(v.nack_at, (v.strch && v.exp_pulses > 12) ? 20 : 0);
            run_txn(v.dev, v.rg, v.dat, v.nack_at, v.strch, v.extra, -1, o);
            check_txn($sformatf("rnd%0d", n), v, o, prev_err);
            prev_err = v.exp_err;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
